game_vga_display: RTL and testbench

GAME_VGA_DISPLAY -- requirements
Module: game_vga_display

---
 rtl/game_vga_display.sv | 209 ++++++++++++++++++++
 tb/tb_game_vga_display.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_vga_display.sv
// game_vga_display: VGA timing generator for a game pixel pipeline.
// A clock divider produces one pixel strobe every DIV clocks. Horizontal and
// vertical counters present x/y/display_on to the game logic. The colour that
// comes back (RGB_LATENCY clocks later) is aligned with delayed sync/blank
// signals before it reaches the DAC.
// Optional feature: define GAME_VGA_BORDER_EN to force a full-intensity
// one-pixel frame around the visible area.

`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 12
`endif

module game_vga_display #(
    parameter int clk_mhz       = 50,
    parameter int pixel_mhz     = 25,
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int h_front       = 16,
    parameter int h_sync        = 96,
    parameter int h_back        = 48,
    parameter int v_front       = 10,
    parameter int v_sync        = 2,
    parameter int v_back        = 33,
    parameter int RGB_LATENCY   = 1,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`GAME_RGB_WIDTH-1:0] rgb_in,
    output logic                       pixel_strobe,
    output logic                       display_on,
    output logic [w_x-1:0]             x,
    output logic [w_y-1:0]             y,
    output logic                       frame_start,
    output logic                       vga_hsync,
    output logic                       vga_vsync,
    output logic [`GAME_RGB_WIDTH-1:0] vga_rgb
);

    localparam int DIV     = clk_mhz / pixel_mhz;
    localparam int H_TOTAL = screen_width + h_front + h_sync + h_back;
    localparam int V_TOTAL = screen_height + v_front + v_sync + v_back;
    localparam int W_H     = $clog2(H_TOTAL);
    localparam int W_V     = $clog2(V_TOTAL);
    localparam int W_D     = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [W_D-1:0] D_LAST = W_D'(DIV - 1);
    localparam logic [W_H-1:0] H_LAST = W_H'(H_TOTAL - 1);
    localparam logic [W_V-1:0] V_LAST = W_V'(V_TOTAL - 1);

    // Sync pulse windows in counter coordinates.
    localparam int HS_BEG = screen_width + h_front;
    localparam int HS_END = screen_width + h_front + h_sync;
    localparam int VS_BEG = screen_height + v_front;
    localparam int VS_END = screen_height + v_front + v_sync;

    // Pipeline stage layout: bit0 hsync, bit1 vsync, bit2 display_on, bit3 border.
`ifdef GAME_VGA_BORDER_EN
    localparam int SW = 4;
`else
    localparam int SW = 3;
`endif
    // Blanked stage: syncs inactive (high), display off.
    localparam logic [SW-1:0] STAGE_BLANK = SW'(3);

    logic [W_D-1:0]                    r_div;
    logic                              w_tick;
    logic [W_H-1:0]                    r_h;
    logic [W_V-1:0]                    r_v;
    logic                              r_strobe;
    logic                              r_frame_start;
    logic                              r_disp;
    logic                              r_hsync;
    logic                              r_vsync;
    logic [w_x-1:0]                    r_x;
    logic [w_y-1:0]                    r_y;
    logic                              w_disp_now;
    logic                              w_hsync_now;
    logic                              w_vsync_now;
    logic [SW-1:0]                     w_stage0;
    logic [RGB_LATENCY:0][SW-1:0]      w_pipe_in;
    logic [RGB_LATENCY:0][SW-1:0]      r_pipe;
    logic [SW-1:0]                     w_last;
    logic [`GAME_RGB_WIDTH-1:0]        r_rgb;

    assign w_tick      = (r_div == D_LAST);
    assign w_disp_now  = (int'(r_h) < screen_width) && (int'(r_v) < screen_height);
    assign w_hsync_now = !((int'(r_h) >= HS_BEG) && (int'(r_h) < HS_END));
    assign w_vsync_now = !((int'(r_v) >= VS_BEG) && (int'(r_v) < VS_END));

`ifdef GAME_VGA_BORDER_EN
    logic r_border;
    logic w_border_now;
    assign w_border_now = (int'(r_h) == 0) || (int'(r_h) == screen_width - 1) ||
                          (int'(r_v) == 0) || (int'(r_v) == screen_height - 1);
    assign w_stage0 = {r_border, r_disp, r_vsync, r_hsync};
`else
    assign w_stage0 = {r_disp, r_vsync, r_hsync};
`endif

    // Clock divider: counts 0..DIV-1, the wrap cycle is the pixel tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + W_D'(1);
        end
    end

    // Raster counters advance once per pixel tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + W_V'(1);
            end else begin
                r_h <= r_h + W_H'(1);
            end
        end
    end

    // Present the pre-increment position and its sync/blank state to the game.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe      <= 1'b0;
            r_frame_start <= 1'b0;
            r_disp        <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_x           <= '0;
            r_y           <= '0;
`ifdef GAME_VGA_BORDER_EN
            r_border      <= 1'b0;
`endif
        end else begin
            r_strobe      <= w_tick;
            r_frame_start <= w_tick && (r_h == '0) && (r_v == '0);
            if (w_tick) begin
                r_disp  <= w_disp_now;
                r_hsync <= w_hsync_now;
                r_vsync <= w_vsync_now;
                r_x     <= w_x'(r_h);
                r_y     <= w_y'(r_v);
`ifdef GAME_VGA_BORDER_EN
                r_border <= w_border_now && w_disp_now;
`endif
            end
        end
    end

    // Shift-register input: stage 0 takes the presented state, others chain.
    generate
        for (genvar gi = 0; gi <= RGB_LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_first
                assign w_pipe_in[gi] = w_stage0;
            end else begin : g_chain
                assign w_pipe_in[gi] = r_pipe[gi-1];
            end
        end
    endgenerate

    // Delay sync/blank by RGB_LATENCY+1 clocks to line up with the sampled colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= {(RGB_LATENCY + 1){STAGE_BLANK}};
        end else begin
            r_pipe <= w_pipe_in;
        end
    end

    // Capture the game colour; it is valid RGB_LATENCY clocks after x/y moved.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= rgb_in;
        end
    end

    assign w_last = r_pipe[RGB_LATENCY];

    // Blank the colour outside the visible area (and paint the border if enabled).
    always_comb begin
        vga_rgb = '0;
        if (w_last[2]) begin
            vga_rgb = r_rgb;
`ifdef GAME_VGA_BORDER_EN
            if (w_last[3]) begin
                vga_rgb = '1;
            end
`endif
        end
    end

    assign pixel_strobe = r_strobe;
    assign frame_start  = r_frame_start;
    assign display_on   = r_disp;
    assign x            = r_x;
    assign y            = r_y;
    assign vga_hsync    = w_last[0];
    assign vga_vsync    = w_last[1];

endmodule

// File: tb/tb_game_vga_display.sv
// Bench for game_vga_display on a reduced raster (20x12 visible, 28x17 total,
// DIV=2, RGB_LATENCY=1) so several whole frames fit in a short run.
// Hand-computed table checks plus a closed-form reference model every clock.

`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 12
`endif

module tb_game_vga_display;

    localparam int CLK_MHZ = 50;
    localparam int PIX_MHZ = 25;
    localparam int DIV     = CLK_MHZ / PIX_MHZ;
    localparam int SWID    = 20;
    localparam int SHGT    = 12;
    localparam int HF      = 2;
    localparam int HSW     = 3;
    localparam int HB      = 3;
    localparam int VF      = 1;
    localparam int VSW     = 2;
    localparam int VB      = 2;
    localparam int LAT     = 1;
    localparam int HT      = SWID + HF + HSW + HB;
    localparam int VT      = SHGT + VF + VSW + VB;
    localparam int WX      = $clog2(SWID);
    localparam int WY      = $clog2(SHGT);
    localparam int RW      = `GAME_RGB_WIDTH;

    localparam int F_STB = 0;
    localparam int F_FS  = 1;
    localparam int F_X   = 2;
    localparam int F_Y   = 3;
    localparam int F_DE  = 4;
    localparam int F_HS  = 5;
    localparam int F_VS  = 6;
    localparam int F_RGB = 7;

    typedef struct {
        int n;
        int sel;
        int val;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] rgb_in = '0;
    logic          pixel_strobe;
    logic          display_on;
    logic [WX-1:0] x;
    logic [WY-1:0] y;
    logic          frame_start;
    logic          vga_hsync;
    logic          vga_vsync;
    logic [RW-1:0] vga_rgb;

    int            n_vec = 0;
    int            n_bad = 0;
    int            n_edge = 0;
    int            rgb_mode = 0;
    logic [RW-1:0] rgb_cur = '0;
    vec_t          tab[$];

    game_vga_display #(
        .clk_mhz(CLK_MHZ), .pixel_mhz(PIX_MHZ),
        .screen_width(SWID), .screen_height(SHGT),
        .h_front(HF), .h_sync(HSW), .h_back(HB),
        .v_front(VF), .v_sync(VSW), .v_back(VB),
        .RGB_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in),
        .pixel_strobe(pixel_strobe), .display_on(display_on),
        .x(x), .y(y), .frame_start(frame_start),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_rgb(vga_rgb)
    );

    always #5 clk = ~clk;

    // Raster state presented after clock edge m (m counted from reset release).
    function automatic void pix(input int m, output int px, output int py,
                                output bit pd, output bit phs, output bit pvs,
                                output bit pb);
        int q, h, v;
        if (m < DIV) begin
            px = 0; py = 0; pd = 1'b0; phs = 1'b1; pvs = 1'b1; pb = 1'b0;
        end else begin
            q   = m / DIV - 1;
            h   = q % HT;
            v   = (q / HT) % VT;
            px  = h % (1 << WX);
            py  = v % (1 << WY);
            pd  = (h < SWID) && (v < SHGT);
            phs = !((h >= SWID + HF) && (h < SWID + HF + HSW));
            pvs = !((v >= SHGT + VF) && (v < SHGT + VF + VSW));
            pb  = (h == 0) || (h == SWID - 1) || (v == 0) || (v == SHGT - 1);
        end
    endfunction

    task automatic check_model();
        int px, py, dx, dy;
        bit pd, phs, pvs, pb, dd, dhs, dvs, db;
        bit e_stb, e_fs;
        logic [WX-1:0] e_x;
        logic [WY-1:0] e_y;
        logic [RW-1:0] e_rgb;
        pix(n_edge, px, py, pd, phs, pvs, pb);
        pix(n_edge - LAT - 1, dx, dy, dd, dhs, dvs, db);
        e_stb = (n_edge >= 1) && (n_edge % DIV == 0);
        e_fs  = e_stb && (((n_edge / DIV - 1) % (HT * VT)) == 0);
        e_x   = WX'(px);
        e_y   = WY'(py);
        e_rgb = '0;
        if (dd) e_rgb = rgb_cur;
`ifdef GAME_VGA_BORDER_EN
        if (dd && db) e_rgb = '1;
`endif
        n_vec++;
        if (pixel_strobe !== e_stb || frame_start !== e_fs || x !== e_x || y !== e_y ||
            display_on !== pd || vga_hsync !== dhs || vga_vsync !== dvs || vga_rgb !== e_rgb) begin
            n_bad++;
            $display("FAIL model n=%0d got stb=%0b fs=%0b x=%0d y=%0d de=%0b hs=%0b vs=%0b rgb=%0h want stb=%0b fs=%0b x=%0d y=%0d de=%0b hs=%0b vs=%0b rgb=%0h",
                     n_edge, pixel_strobe, frame_start, x, y, display_on, vga_hsync, vga_vsync, vga_rgb,
                     e_stb, e_fs, e_x, e_y, pd, dhs, dvs, e_rgb);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later and check.
    task automatic tick(input bit r);
        rst = r;
        case (rgb_mode)
            0:       rgb_in = RW'($urandom);
            1:       rgb_in = '1;
            default: rgb_in = '0;
        endcase
        rgb_cur = rgb_in;
        @(posedge clk);
        if (r) n_edge = 0;
        else   n_edge++;
        #1;
        check_model();
    endtask

    function automatic logic [31:0] field(input int sel);
        case (sel)
            F_STB:   field = 32'(pixel_strobe);
            F_FS:    field = 32'(frame_start);
            F_X:     field = 32'(x);
            F_Y:     field = 32'(y);
            F_DE:    field = 32'(display_on);
            F_HS:    field = 32'(vga_hsync);
            F_VS:    field = 32'(vga_vsync);
            default: field = 32'(vga_rgb);
        endcase
    endfunction

    function automatic string fname(input int sel);
        case (sel)
            F_STB:   fname = "pixel_strobe";
            F_FS:    fname = "frame_start";
            F_X:     fname = "x";
            F_Y:     fname = "y";
            F_DE:    fname = "display_on";
            F_HS:    fname = "vga_hsync";
            F_VS:    fname = "vga_vsync";
            default: fname = "vga_rgb";
        endcase
    endfunction

    task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s n=%0d got=%0d want=%0d", name, n_edge, got, want);
        end
    endtask

    task automatic add(input int n, input int sel, input int val);
        vec_t v;
        v.n = n; v.sel = sel; v.val = val;
        tab.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at n=%0d", n_edge);
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_left;
        // Expected values hand-derived for the 28x17 raster, DIV=2, latency 1.
        add(0, F_STB, 0);  add(0, F_FS, 0);  add(0, F_X, 0);   add(0, F_Y, 0);
        add(0, F_DE, 0);   add(0, F_HS, 1);  add(0, F_VS, 1);  add(0, F_RGB, 0);
        add(1, F_STB, 0);  add(1, F_DE, 0);  add(1, F_FS, 0);
        add(2, F_STB, 1);  add(2, F_FS, 1);  add(2, F_X, 0);   add(2, F_Y, 0);  add(2, F_DE, 1);
        add(3, F_STB, 0);  add(3, F_FS, 0);  add(3, F_X, 0);   add(3, F_DE, 1); add(3, F_RGB, 0);
        add(4, F_STB, 1);  add(4, F_X, 1);   add(4, F_FS, 0);
        add(40, F_X, 19);  add(40, F_DE, 1);
        add(42, F_X, 20);  add(42, F_DE, 0);
        add(47, F_HS, 1);  add(48, F_HS, 0); add(53, F_HS, 0); add(54, F_HS, 1);
        add(56, F_X, 27);
        add(58, F_X, 0);   add(58, F_Y, 1);  add(58, F_DE, 1); add(58, F_FS, 0);
        add(656, F_X, 19); add(656, F_Y, 11); add(656, F_DE, 1);
        add(674, F_Y, 12); add(674, F_DE, 0);
        add(731, F_VS, 1); add(732, F_VS, 0); add(843, F_VS, 0); add(844, F_VS, 1);
        add(952, F_X, 27); add(952, F_Y, 0); add(952, F_DE, 0);
        add(954, F_FS, 1); add(954, F_STB, 1); add(954, F_X, 0); add(954, F_Y, 0); add(954, F_DE, 1);

        // Hold reset, then walk the first frame through the table.
        for (int i = 0; i < 3; i++) tick(1'b1);
        for (int i = 0; i < tab.size(); i++) begin
            while (n_edge < tab[i].n) tick(1'b0);
            n_vec++;
            if (field(tab[i].sel) !== 32'(tab[i].val)) begin
                n_bad++;
                $display("FAIL table[%0d] n=%0d %s got=%0d want=%0d",
                         i, tab[i].n, fname(tab[i].sel), field(tab[i].sel), tab[i].val);
            end
        end

        // Reset pulsed mid-frame at h=10, v=5 of the second frame.
        while (n_edge < 1254) tick(1'b0);
        expect_eq("pre_rst_x", 32'(x), 32'd10);
        expect_eq("pre_rst_y", 32'(y), 32'd5);
        tick(1'b1);
        expect_eq("rst_strobe", 32'(pixel_strobe), 32'd0);
        expect_eq("rst_fs", 32'(frame_start), 32'd0);
        expect_eq("rst_x", 32'(x), 32'd0);
        expect_eq("rst_y", 32'(y), 32'd0);
        expect_eq("rst_de", 32'(display_on), 32'd0);
        expect_eq("rst_hs", 32'(vga_hsync), 32'd1);
        expect_eq("rst_vs", 32'(vga_vsync), 32'd1);
        expect_eq("rst_rgb", 32'(vga_rgb), 32'd0);
        tick(1'b0);
        expect_eq("rel1_fs", 32'(frame_start), 32'd0);
        expect_eq("rel1_strobe", 32'(pixel_strobe), 32'd0);
        tick(1'b0);
        expect_eq("rel2_fs", 32'(frame_start), 32'd1);
        expect_eq("rel2_strobe", 32'(pixel_strobe), 32'd1);

        // Colour held at all-ones, then at zero, across a full frame each.
        rgb_mode = 1;
        for (int i = 0; i < 1000; i++) tick(1'b0);
        rgb_mode = 2;
        for (int i = 0; i < 1000; i++) tick(1'b0);

        // Random colour with occasional short reset pulses.
        rgb_mode = 0;
        rst_left = 0;
        for (int i = 0; i < 2500; i++) begin
            if (rst_left == 0 && $urandom_range(0, 299) == 0)
                rst_left = int'($urandom_range(1, 3));
            if (rst_left > 0) begin
                rst_left--;
                tick(1'b1);
            end else begin
                tick(1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
